// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller and its opcode decoder.
//   state_t     : controller state, also exported on the 4-bit debug port
//   OP_* / FN_* : opcode and funct values recognised by the decoder
//   SRCB_*, ALUOP_*, PCSRC_* : datapath mux / ALU operation encodings
//   op_class_t  : one-hot-ish instruction class produced by mips_op_decode
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        EXT    = 4'd9
    } state_t;

    localparam int OP_RTYPE = 0;
    localparam int OP_LW    = 35;
    localparam int OP_SW    = 43;
    localparam int OP_BEQ   = 4;
    localparam int OP_BMN   = 21;
    localparam int OP_BZ    = 24;
    localparam int OP_JALM  = 19;
    localparam int OP_JSPAL = 22;
    localparam int FN_BRZ   = 20;
    localparam int FN_JMOR  = 37;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SHIMM = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_EXT    = 2'b11;

    typedef struct packed {
        logic rformat;
        logic lw;
        logic sw;
        logic beq;
        logic bmn;
        logic bz;
        logic jalm;
        logic jspal;
        logic brz;
        logic jmor;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Memory and extension-unit handshake bundle of the multi-cycle controller.
//   memread/memwrite/iord : memory strobes and address select (controller drives)
//   mem_ready             : memory access completes this cycle
//   ext_valid             : extension request (controller drives)
//   ext_done/ext_take     : extension finished / extension requests PC load
// Handshakes: mem_ready completes the access strobed in the same cycle; an
// extension request is held (ext_valid) until the cycle ext_done is high, and
// ext_take is only meaningful in that ext_done cycle.
interface multicycle_control_if;

    logic memread;
    logic memwrite;
    logic iord;
    logic mem_ready;
    logic ext_valid;
    logic ext_done;
    logic ext_take;

    modport master (
        output memread, memwrite, iord, ext_valid,
        input  mem_ready, ext_done, ext_take
    );

    modport slave (
        input  memread, memwrite, iord, ext_valid,
        output mem_ready, ext_done, ext_take
    );

endinterface

// File: rtl/mips_op_decode.sv
// Combinational instruction-class and status decode from op/funct.
//   op, funct : instruction register fields
//   cls       : instruction class (exactly one bit set)
//   status    : 3-bit extended-op status vector
module mips_op_decode
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 6
) (
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    output op_class_t          cls,
    output logic [2:0]         status
);

    logic is_r;

    always_comb begin
        is_r        = (op == OP_W'(OP_RTYPE));
        cls         = '0;
        cls.brz     = is_r && (funct == FUNCT_W'(FN_BRZ));
        cls.jmor    = is_r && (funct == FUNCT_W'(FN_JMOR));
        cls.rformat = is_r && !cls.brz && !cls.jmor;
        cls.lw      = (op == OP_W'(OP_LW));
        cls.sw      = (op == OP_W'(OP_SW));
        cls.beq     = (op == OP_W'(OP_BEQ));
        cls.bmn     = (op == OP_W'(OP_BMN));
        cls.bz      = (op == OP_W'(OP_BZ));
        cls.jalm    = (op == OP_W'(OP_JALM));
        cls.jspal   = (op == OP_W'(OP_JSPAL));
        cls.illegal = !(cls.rformat | cls.lw | cls.sw | cls.beq | cls.bmn |
                        cls.bz | cls.jalm | cls.jspal | cls.brz | cls.jmor);

        status[0] = cls.beq | cls.bmn | cls.bz  | cls.jalm;
        status[1] = cls.beq | cls.brz | cls.bz  | cls.jspal;
        status[2] = cls.beq | cls.jmor | cls.jalm | cls.jspal;
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// sequencing with a mem_ready stall and an ext_valid/ext_done extension
// handshake with timeout.
//   clk, reset       : clock, asynchronous active-high reset
//   op, funct        : instruction register fields
//   bus (master)     : memory strobes and extension handshake
//   pcwrite..pcsource: datapath/register-file control
//   status           : status latched in DECODE
//   state            : current state (debug)
//   illegal          : sticky illegal-opcode / extension-timeout flag
// STATUS_W must be at least 3.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W          = 6,
    parameter int FUNCT_W       = 6,
    parameter int STATUS_W      = 3,
    parameter int MEM_HANDSHAKE = 1,
    parameter int EXT_TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OP_W-1:0]      op,
    input  logic [FUNCT_W-1:0]   funct,
    multicycle_control_if.master bus,
    output logic                 pcwrite,
    output logic                 pcwritecond,
    output logic                 irwrite,
    output logic                 memtoreg,
    output logic                 regdest,
    output logic                 regwrite,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic [1:0]           aluop,
    output logic [1:0]           pcsource,
    output logic [STATUS_W-1:0]  status,
    output logic [3:0]           state,
    output logic                 illegal
);

    localparam int CNT_W = $clog2(EXT_TIMEOUT + 1);

    state_t              state_q, next_state;
    op_class_t           cls;
    logic [2:0]          status_dec;
    logic [STATUS_W-1:0] status_q;
    logic [STATUS_W-1:0] status_ext;
    logic                illegal_q;
    logic                set_illegal;
    logic [CNT_W-1:0]    ext_cnt;
    logic                ext_expired;
    logic                mem_ok;

    mips_op_decode #(.OP_W(OP_W), .FUNCT_W(FUNCT_W)) u_decode (
        .op     (op),
        .funct  (funct),
        .cls    (cls),
        .status (status_dec)
    );

    assign mem_ok      = (MEM_HANDSHAKE == 0) ? 1'b1 : bus.mem_ready;
    // Last allowed EXT cycle; ext_done in this cycle still wins.
    assign ext_expired = (ext_cnt == CNT_W'(EXT_TIMEOUT - 1));

    always_comb begin
        status_ext      = '0;
        status_ext[2:0] = status_dec;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            status_q  <= '0;
            illegal_q <= 1'b0;
            ext_cnt   <= '0;
        end else begin
            state_q <= next_state;
            if (state_q == DECODE)
                status_q <= status_ext;
            if (set_illegal)
                illegal_q <= 1'b1;
            if (state_q == EXT && !bus.ext_done && !ext_expired)
                ext_cnt <= ext_cnt + CNT_W'(1);
            else
                ext_cnt <= '0;
        end
    end

    always_comb begin
        next_state    = state_q;
        set_illegal   = 1'b0;
        pcwrite       = 1'b0;
        pcwritecond   = 1'b0;
        irwrite       = 1'b0;
        memtoreg      = 1'b0;
        regdest       = 1'b0;
        regwrite      = 1'b0;
        alusrca       = 1'b0;
        alusrcb       = SRCB_REG;
        aluop         = ALUOP_ADD;
        pcsource      = PCSRC_ALU;
        bus.memread   = 1'b0;
        bus.memwrite  = 1'b0;
        bus.iord      = 1'b0;
        bus.ext_valid = 1'b0;

        case (state_q)
            FETCH: begin
                bus.memread = 1'b1;
                alusrcb     = SRCB_FOUR;
                if (mem_ok) begin
                    irwrite    = 1'b1;
                    pcwrite    = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                alusrcb = SRCB_SHIMM;
                if (cls.lw | cls.sw | cls.bmn | cls.jmor | cls.jalm | cls.jspal)
                    next_state = MEMADR;
                else if (cls.rformat)
                    next_state = EXEC;
                else if (cls.beq)
                    next_state = BRANCH;
                else if (cls.brz | cls.bz)
                    next_state = EXT;
                else begin
                    set_illegal = cls.illegal;
                    next_state  = FETCH;
                end
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_IMM;
                next_state = cls.sw ? MEMWR : MEMRD;
            end
            MEMRD: begin
                bus.memread = 1'b1;
                bus.iord    = 1'b1;
                if (mem_ok)
                    next_state = cls.lw ? MEMWB : EXT;
            end
            MEMWB: begin
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                next_state = FETCH;
            end
            MEMWR: begin
                bus.memwrite = 1'b1;
                bus.iord     = 1'b1;
                if (mem_ok)
                    next_state = FETCH;
            end
            EXEC: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_FUNCT;
                next_state = ALUWB;
            end
            ALUWB: begin
                regwrite   = 1'b1;
                regdest    = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                alusrca     = 1'b1;
                aluop       = ALUOP_SUB;
                pcwritecond = 1'b1;
                pcsource    = PCSRC_ALUOUT;
                next_state  = FETCH;
            end
            EXT: begin
                bus.ext_valid = 1'b1;
                if (bus.ext_done) begin
                    pcwrite    = bus.ext_take;
                    pcsource   = PCSRC_EXT;
                    // Among extended ops only jmor/jalm/jspal have status[2]
                    // set, and those are the ones that write the register file.
                    regwrite   = status_q[2];
                    memtoreg   = status_q[2];
                    next_state = FETCH;
                end else if (ext_expired) begin
                    set_illegal = 1'b1;
                    next_state  = FETCH;
                end
            end
            default: next_state = FETCH;
        endcase

        // Reset forces every control output low at once, even though the
        // state register already reads FETCH.
        if (reset) begin
            pcwrite       = 1'b0;
            pcwritecond   = 1'b0;
            irwrite       = 1'b0;
            memtoreg      = 1'b0;
            regdest       = 1'b0;
            regwrite      = 1'b0;
            alusrca       = 1'b0;
            alusrcb       = 2'b00;
            aluop         = 2'b00;
            pcsource      = 2'b00;
            bus.memread   = 1'b0;
            bus.memwrite  = 1'b0;
            bus.iord      = 1'b0;
            bus.ext_valid = 1'b0;
        end
    end

    assign state   = state_q;
    assign status  = status_q;
    assign illegal = illegal_q;

endmodule
